// File: rtl/bn_var_stats.sv
// Batch-norm statistics: accumulates N = 2^LOG2N signed samples and produces the batch mean
// and var+eps for the downstream sqrt unit, holding both until the consumer takes them.
module bn_var_stats #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int LOG2N = 4,
    parameter int EPS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IL+FL-1:0] in,
    input  logic                    in_valid,
    output logic                    in_accept,
    output logic signed [IL+FL-1:0] mean,
    output logic [IL+FL-1:0]        out,
    output logic                    out_ready,
    input  logic                    output_taken,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int W    = IL + FL;
    localparam int SQW  = 2 * IL + FL;
    localparam int SUMW = W + LOG2N;
    localparam int SSQW = SQW + LOG2N;
    localparam int N    = 1 << LOG2N;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        CALC  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t cur, nxt;

    // Squared sample rescaled to FL fraction bits; the product is never negative.
    function automatic logic [SQW-1:0] sq(input logic signed [W-1:0] x);
        logic signed [2*W-1:0] p;
        p = x * x;
        return p[2*W-1:FL];
    endfunction

    // Variance is clamped at zero (E[x^2] can fall below mean^2 through truncation),
    // then EPS is added and the result saturates to the unsigned output range.
    function automatic logic [W-1:0] var_eps(input logic [SQW-1:0] ex2,
                                             input logic [SQW-1:0] msq);
        logic [SQW:0] v;
        v = (ex2 < msq) ? '0 : {1'b0, ex2 - msq};
        v = v + (SQW+1)'(EPS);
        if (v > (SQW+1)'({W{1'b1}}))
            return {W{1'b1}};
        return v[W-1:0];
    endfunction

    logic signed [SUMW-1:0] sum_p0;
    logic [SSQW-1:0]        sumsq_p0;
    logic [LOG2N-1:0]       count_p0;
    logic signed [W-1:0]    mean_p1;
    logic [W-1:0]           out_p1;
    logic                   out_ready_p1;

    logic                   accept;
    logic signed [W-1:0]    mean_c;
    logic [SQW-1:0]         ex2_c;
    logic [SQW-1:0]         msq_c;

    assign in_accept = (cur == IDLE) || (cur == ACCUM);
    assign accept    = in_valid && in_accept;

    // Dividing by N is a plain shift: the upper bits of the accumulators.
    assign mean_c = sum_p0[SUMW-1:LOG2N];
    assign ex2_c  = sumsq_p0[SSQW-1:LOG2N];
    assign msq_c  = sq(mean_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:  if (in_valid) nxt = ACCUM;
            ACCUM: if (in_valid && (count_p0 == LOG2N'(N - 1))) nxt = CALC;
            CALC:  nxt = DONE;
            DONE:  if (output_taken) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Stage p0: sample accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_p0   <= '0;
            sumsq_p0 <= '0;
            count_p0 <= '0;
        end else if (accept) begin
            if (cur == IDLE) begin
                sum_p0   <= SUMW'(in);
                sumsq_p0 <= SSQW'(sq(in));
                count_p0 <= LOG2N'(1);
            end else begin
                sum_p0   <= sum_p0 + SUMW'(in);
                sumsq_p0 <= sumsq_p0 + SSQW'(sq(in));
                count_p0 <= count_p0 + LOG2N'(1);
            end
        end else if ((cur == DONE) && output_taken) begin
            sum_p0   <= '0;
            sumsq_p0 <= '0;
            count_p0 <= '0;
        end
    end

    // Stage p1: result registers, loaded once in CALC and held through DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mean_p1      <= '0;
            out_p1       <= '0;
            out_ready_p1 <= 1'b0;
        end else begin
            if (cur == CALC) begin
                mean_p1 <= mean_c;
                out_p1  <= var_eps(ex2_c, msq_c);
            end
            out_ready_p1 <= (cur == CALC);
        end
    end

    assign mean      = mean_p1;
    assign out       = out_p1;
    assign out_ready = out_ready_p1;
    assign state     = cur;
    assign done      = (cur == DONE);

endmodule

// File: tb/tb_bn_var_stats.sv
// Randomized scoreboard bench for bn_var_stats: batches are scored against a plain-arithmetic
// model of the batch statistics; a monitor checks every out_ready presentation.
module tb_bn_var_stats;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [19:0] in_s = '0;
    logic               in_valid = 1'b0;
    logic               output_taken = 1'b0;
    logic               in_accept;
    logic signed [19:0] mean;
    logic [19:0]        out;
    logic               out_ready;
    logic [1:0]         state;
    logic               done;

    int     n_checks = 0;
    int     n_fail = 0;
    int     pulses = 0;
    int     batches = 0;
    int     samp[16];
    longint exp_mean_q[$];
    longint exp_out_q[$];
    longint last_mean, last_out;

    always #5 clk = ~clk;

    bn_var_stats #(.IL(4), .FL(16), .LOG2N(4), .EPS(1)) dut (
        .clk(clk), .reset(reset), .in(in_s), .in_valid(in_valid), .in_accept(in_accept),
        .mean(mean), .out(out), .out_ready(out_ready), .output_taken(output_taken),
        .state(state), .done(done)
    );

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Batch statistics straight from the definitions, with floor division.
    function automatic void model(output longint m, output longint o);
        longint s = 0, ss = 0, e2, msq, v;
        foreach (samp[i]) begin
            s  += samp[i];
            ss += (longint'(samp[i]) * samp[i]) / 65536;
        end
        m   = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        e2  = ss / 16;
        msq = (m * m) / 65536;
        v   = e2 - msq;
        if (v < 0) v = 0;
        o = v + 1;
        if (o > 1048575) o = 1048575;
    endfunction

    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && out_ready === 1'b1) begin
                pulses++;
                chk("out_ready_one_cycle", longint'(prev), 0);
                if (exp_mean_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got mean %0d out %0d, expected none", mean, out);
                end else begin
                    chk("mean", mean, exp_mean_q.pop_front());
                    chk("out", out, exp_out_q.pop_front());
                    chk("done_with_ready", done, 1);
                end
            end
            prev = out_ready;
        end
    end

    task automatic send_batch(input int gapmax, input bit hold);
        longint m, o;
        model(m, o);
        exp_mean_q.push_back(m);
        exp_out_q.push_back(o);
        last_mean = m;
        last_out  = o;
        batches++;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, gapmax)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_s = 20'(samp[i]);
            in_valid = 1'b1;
            chk("in_accept_before_sample", in_accept, 1);
            @(posedge clk); #1;
        end
        if (hold) in_s = 20'sh7FFFF;
        else in_valid = 1'b0;
        chk("state_calc_after_nth", state, 2);
        chk("no_accept_in_calc", in_accept, 0);
        @(posedge clk); #1;
        chk("state_done", state, 3);
        chk("done_set", done, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_held", done, 1);
            chk("no_accept_in_done", in_accept, 0);
            chk("out_ready_low_later", out_ready, 0);
            chk("mean_held", mean, last_mean);
            chk("out_held", out, last_out);
        end
        output_taken = 1'b1;
        @(posedge clk); #1;
        output_taken = 1'b0;
        in_valid = 1'b0;
        chk("state_idle_after_taken", state, 0);
        chk("done_clear_after_taken", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? a : b;
    endtask

    initial begin
        logic [19:0] r;
        #1;
        chk("reset_state", state, 0);
        chk("reset_done", done, 0);
        chk("reset_out", out, 0);
        chk("reset_mean", mean, 0);
        chk("reset_out_ready", out_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        fill(65536, 65536);       send_batch(0, 0);
        fill(65536, -65536);      send_batch(3, 0);
        fill(131072, 0);          send_batch(0, 0);
        fill(524287, -524288);    send_batch(1, 0);
        fill(-524288, -524288);   send_batch(0, 0);

        // Abort a batch mid-accumulation; no residue may survive into the next one.
        for (int i = 0; i < 5; i++) begin
            in_s = 20'sd65536;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("state_accum_before_abort", state, 1);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort_state", state, 0);
        chk("abort_done", done, 0);
        chk("abort_out", out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        fill(65536, 65536);       send_batch(0, 0);

        // in_valid held high through CALC/DONE and the output_taken cycle.
        fill(65536, 65536);       send_batch(0, 1);
        fill(65536, 65536);       send_batch(2, 0);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) begin
                r = 20'($urandom);
                samp[i] = (b == 0) ? int'($urandom_range(0, 131072)) - 65536 : int'($signed(r));
            end
            send_batch(2, 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_mean_q.size(), 0);
        chk("out_ready_pulse_count", pulses, batches);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
